// File: rtl/fi_pkg.sv
// fi_pkg -- shared definitions for the saturating fixed-point blocks.
//
// Contents:
//   FI_WS, FI_DP    default word width and fractional bit count (Q8.8)
//   state_e         sequencer states of the iterative divider
//   fi_max/fi_min   largest / smallest signed value of a ws-bit word,
//                   returned as int (valid for ws <= 31)
package fi_pkg;

   localparam int FI_WS = 16;
   localparam int FI_DP = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic int fi_max(input int ws);
      return (1 << (ws - 1)) - 1;
   endfunction

   function automatic int fi_min(input int ws);
      return -(1 << (ws - 1));
   endfunction

endpackage

// File: rtl/fi_sat.sv
// fi_sat -- combinational saturation stage for signed fixed-point results.
//
// Turns an unsigned magnitude plus sign into a signed ws-bit word, clamping
// to the representable range. The negative range is one larger than the
// positive range, so a magnitude of exactly 2^(WS-1) is legal when negative.
//
// Ports:
//   mag   in   MW  unsigned result magnitude
//   sign  in   1   result is negative; when zero=1 this is the dividend sign
//   zero  in   1   divisor was zero: clamp toward the dividend's sign
//   c     out  WS  signed saturated result
//   ovf   out  1   magnitude exceeded the limit and was clamped
//   dz    out  1   divide-by-zero result
module fi_sat
   import fi_pkg::*;
#(
   parameter int WS = FI_WS,
   parameter int MW = FI_WS + FI_DP
) (
   input  logic [MW-1:0] mag,
   input  logic          sign,
   input  logic          zero,
   output logic [WS-1:0] c,
   output logic          ovf,
   output logic          dz
);

   localparam int            MAX_I = fi_max(WS);
   localparam int            MIN_I = fi_min(WS);
   localparam logic [WS-1:0] C_MAX = MAX_I[WS-1:0];
   localparam logic [WS-1:0] C_MIN = MIN_I[WS-1:0];

   logic [MW-1:0] lim;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      c   = '0;
      ovf = 1'b0;
      dz  = 1'b0;
      // 2^(WS-1)-1 for positive results, 2^(WS-1) for negative ones.
      lim = {{(MW-WS){1'b0}}, C_MAX} + {{(MW-1){1'b0}}, sign};
      if (zero) begin
         dz = 1'b1;
         c  = sign ? C_MIN : C_MAX;
      end else if (mag > lim) begin
         ovf = 1'b1;
         c   = sign ? C_MIN : C_MAX;
      end else begin
         c = sign ? -mag[WS-1:0] : mag[WS-1:0];
      end
   end

endmodule

// File: rtl/fi_div_seq.sv
// fi_div_seq -- multi-cycle signed fixed-point divider, c = a / b.
//
// All operands are Q(ws-dp).dp. Radix-2 restoring division produces one
// quotient bit per clock over N = ws+dp cycles using a single subtractor.
// Sequence: IDLE (accept) -> CALC (N cycles) -> FIX (saturate) -> DONE
// (hold until taken). Result appears N+1 clocks after the accepting edge.
//
// Build option: define FI_DIV_ROUND_EN to round half away from zero in FIX;
// otherwise the quotient is truncated toward zero. Latency is unchanged.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high; aborts any division
//   in_valid   in   1   a/b valid
//   in_ready   out  1   high in IDLE only
//   a          in   ws  signed dividend
//   b          in   ws  signed divisor
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   downstream takes the result
//   c          out  ws  signed quotient
//   ovf        out  1   result saturated
//   dz         out  1   divisor was zero
module fi_div_seq
   import fi_pkg::*;
#(
   parameter int ws = FI_WS,
   parameter int dp = FI_DP
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [ws-1:0] a,
   input  logic [ws-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [ws-1:0] c,
   output logic          ovf,
   output logic          dz
);

   localparam int N  = ws + dp;
   localparam int CW = $clog2(N);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [N-1:0]    dvd_q,   dvd_d;    // |a| << dp, consumed MSB first
   logic [ws:0]     div_q,   div_d;    // |b|
   logic [ws:0]     rem_q,   rem_d;    // partial remainder
   logic [N-1:0]    quo_q,   quo_d;
   logic            sign_q,  sign_d;
   logic            zero_q,  zero_d;
   logic [ws-1:0]   c_q,     c_d;
   logic            ovf_q,   ovf_d;
   logic            dz_q,    dz_d;

   // Magnitudes are taken in ws+1 bits so -2^(ws-1) becomes +2^(ws-1) exactly.
   logic [ws:0]     a_ext, a_abs, b_ext, b_abs;
   logic [ws+1:0]   rem_sh, trial;
   logic            take;
   logic [N-1:0]    mag_fix;
   logic [ws-1:0]   sat_c;
   logic            sat_ovf, sat_dz;

`ifdef FI_DIV_ROUND_EN
   // Round half away from zero: bump the magnitude when 2*rem >= |b|.
   assign mag_fix = ({rem_q, 1'b0} >= {1'b0, div_q}) ? quo_q + N'(1) : quo_q;
`else
   assign mag_fix = quo_q;
`endif

   fi_sat #(
      .WS (ws),
      .MW (N)
   ) u_sat (
      .mag  (mag_fix),
      .sign (sign_q),
      .zero (zero_q),
      .c    (sat_c),
      .ovf  (sat_ovf),
      .dz   (sat_dz)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;

      a_ext = {a[ws-1], a};
      b_ext = {b[ws-1], b};
      a_abs = a[ws-1] ? -a_ext : a_ext;
      b_abs = b[ws-1] ? -b_ext : b_ext;

      // One restoring step: shift in the next dividend bit, trial-subtract |b|.
      rem_sh = {rem_q, dvd_q[N-1]};
      trial  = rem_sh - {1'b0, div_q};
      take   = ~trial[ws+1];

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // The upper bit of a_abs is shifted out; it is only set for
               // |a| = 2^ws, which cannot occur.
               dvd_d   = N'(a_abs) << dp;
               div_d   = b_abs;
               rem_d   = '0;
               quo_d   = '0;
               // With b = 0 this reduces to a's sign, which is exactly the
               // direction the divide-by-zero clamp needs.
               sign_d  = a[ws-1] ^ b[ws-1];
               zero_d  = (b == '0);
               cnt_d   = CW'(N - 1);
               state_d = CALC;
            end
         end
         CALC: begin
            rem_d = take ? trial[ws:0] : rem_sh[ws:0];
            quo_d = {quo_q[N-2:0], take};
            dvd_d = dvd_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIX;
         end
         FIX: begin
            c_d     = sat_c;
            ovf_d   = sat_ovf;
            dz_d    = sat_dz;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
         c_q     <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign c         = c_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule

// File: tb/tb_fi_div_seq.sv
// tb_fi_div_seq -- directed, table-driven bench for fi_div_seq (ws=16, dp=8).
module tb_fi_div_seq;

   localparam int LAT = 25;   // N+1 at ws=16, dp=8

`ifdef FI_DIV_ROUND_EN
   localparam logic [15:0] C_2_3 = 16'h00AB;
`else
   localparam logic [15:0] C_2_3 = 16'h00AA;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] c;
   logic        ovf, dz;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fi_div_seq #(.ws(16), .dp(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .ovf       (ovf),
      .dz        (dz)
   );

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic        ovf;
      logic        dz;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Issue one operand pair, return at the negedge where out_valid is first seen.
   task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                         output logic [15:0] co, output logic ovo, output logic dzo,
                         output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("in_ready before issue", 32'(in_ready), 32'd1);
      a        = ai;
      b        = bi;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 200);
      co  = c;
      ovo = ovf;
      dzo = dz;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rc;
      logic        rovf, rdz;
      int          lat;
      logic        seen_valid;

      vecs[0]  = '{"1.5/0.5",        16'h0180, 16'h0080, 16'h0300, 1'b0, 1'b0};
      vecs[1]  = '{"2/3",            16'h0200, 16'h0300, C_2_3,    1'b0, 1'b0};
      vecs[2]  = '{"-1/3",           16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0};
      vecs[3]  = '{"100/lsb ovf",    16'h6400, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
      vecs[4]  = '{"-128/-1 ovf",    16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0};
      vecs[5]  = '{"-1/0",           16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1};
      vecs[6]  = '{"1/0",            16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
      vecs[7]  = '{"-128/1 exact",   16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
      vecs[8]  = '{"-128/-128",      16'h8000, 16'h8000, 16'h0100, 1'b0, 1'b0};
      vecs[9]  = '{"-1.5/0.5",       16'hFE80, 16'h0080, 16'hFD00, 1'b0, 1'b0};
      vecs[10] = '{"0/-3",           16'h0000, 16'hFD00, 16'h0000, 1'b0, 1'b0};
      vecs[11] = '{"max/1 exact",    16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 1'b0};
      vecs[12] = '{"0/0",            16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset c",         32'(c),         32'd0);
      check("reset ovf",       32'(ovf),       32'd0);
      check("reset dz",        32'(dz),        32'd0);
      rst = 1'b0;

      // Table-driven vectors, result taken immediately.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, rc, rovf, rdz, lat);
         check({vecs[i].name, " c"},   32'(rc),   32'(vecs[i].c));
         check({vecs[i].name, " ovf"}, 32'(rovf), 32'(vecs[i].ovf));
         check({vecs[i].name, " dz"},  32'(rdz),  32'(vecs[i].dz));
         check({vecs[i].name, " latency"}, 32'(lat), 32'(LAT));
      end

      // Back-pressure: hold the result 10 cycles while a new pair waits.
      @(negedge clk);
      out_ready = 1'b0;
      run_op(16'hFF00, 16'h0300, rc, rovf, rdz, lat);
      check("bp c",       32'(rc),  32'h0000FFAB);
      check("bp latency", 32'(lat), 32'(LAT));
      a        = 16'h0200;
      b        = 16'h0300;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp hold c",         32'(c),         32'h0000FFAB);
         check("bp hold ovf",       32'(ovf),       32'd0);
         check("bp hold dz",        32'(dz),        32'd0);
         check("bp hold out_valid", 32'(out_valid), 32'd1);
         check("bp hold in_ready",  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);          // result taken here
      @(negedge clk);
      check("bp after take out_valid", 32'(out_valid), 32'd0);
      check("bp after take in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);          // waiting pair accepted here
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 200);
      check("bp second c",       32'(c),   32'(C_2_3));
      check("bp second latency", 32'(lat), 32'(LAT));

      // Reset in the middle of CALC discards the division.
      @(negedge clk);          // previous result taken on the edge before
      a        = 16'h0180;
      b        = 16'h0080;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid-rst in_ready",  32'(in_ready),  32'd1);
      check("mid-rst out_valid", 32'(out_valid), 32'd0);
      check("mid-rst c",         32'(c),         32'd0);
      seen_valid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      check("mid-rst no result", 32'(seen_valid), 32'd0);
      run_op(16'h0180, 16'h0080, rc, rovf, rdz, lat);
      check("post-rst c",       32'(rc),  32'h00000300);
      check("post-rst latency", 32'(lat), 32'(LAT));

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
